uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// Shares one UART transmitter (the UART_top newd/dintx/donetx port) among NUM_REQ byte sources.
// Round-robin arbitration, one byte per grant. Drives the single-cycle newd pulse, then holds off until donetx or a timeout.
// Sits between local producers (cmd/status/debug) and the UART_top instance.
// PARAMETERS
// clk_freq    1000000  system clock frequency, Hz
// baud_rate   9600     UART bit rate; CLKS_PER_BIT = clk_freq/baud_rate (integer divide)
// NUM_REQ     4        number of requesters, 2..8
// TIMEOUT_MUL 12       timeout = TIMEOUT_MUL*CLKS_PER_BIT cycles in WAIT_DONE
// PORTS
// clk          in   1          system clock, rising edge
// rst          in   1          synchronous, active-high reset
// req_valid    in   NUM_REQ    per-requester byte available; held until accepted
// req_data     in   8*NUM_REQ  byte i at [8*i+7:8*i]; stable while req_valid[i]
// req_ready    out  NUM_REQ    one-hot accept; transfer when req_valid[i]&req_ready[i]
// newd         out  1          start pulse to UART tx
// dintx        out  8          byte to UART tx
// donetx       in   1          UART tx frame-complete pulse
// grant_id     out  clog2(NUM_REQ)  index of requester currently owning the tx
// busy         out  1          high in START and WAIT_DONE
// timeout_err  out  1          1-cycle pulse when WAIT_DONE times out
// BEHAVIOUR
// - Reset: state=IDLE, ptr=0, req_ready=0, newd=0, dintx=8'h00, grant_id=0, busy=0, timeout_err=0, counter=0.
//   rst mid-frame aborts immediately; any in-flight UART frame is not tracked afterwards.
// - FSM states: IDLE -> START -> WAIT_DONE -> IDLE.
// - IDLE: g = first i with req_valid[i], searching ptr, ptr+1, ... mod NUM_REQ.
//   - req_ready is combinational, one-hot at bit g, and only in IDLE with req_valid!=0; 0 in every other state.
//   - On the accept edge: dintx<=req_data[g], grant_id<=g, ptr<=(g+1) mod NUM_REQ, state<=START.
// - START: newd=1 for exactly one cycle; state<=WAIT_DONE; counter<=0.
//   - Latency: accept in cycle n -> newd in cycle n+1.
// - WAIT_DONE: counter increments each cycle.
//   - donetx=1 -> IDLE; the next grant can be accepted in the following cycle.
//   - counter==TIMEOUT-1 without donetx -> timeout_err=1 for one cycle, state<=IDLE.
//   - donetx in the same cycle as the timeout: done wins, no timeout_err.
// - dintx and grant_id hold their value until the next accept; newd never pulses twice per grant.
// - donetx outside WAIT_DONE is ignored.
// - req_valid dropping without an accept is legal; requesters not granted wait with no starvation.
//   Worst-case wait is NUM_REQ-1 frames.
// - Counter width: clog2(TIMEOUT)+1 bits; no wrap-around within a frame.
// - busy = (state!=IDLE), registered with state.
// TESTING
// Defaults: CLKS_PER_BIT=104, TIMEOUT=1248; loop UART_top tx->rx for data checks.
// - Single req: req_valid=4'b0001, data 8'hA5 -> req_ready[0] same cycle; newd next cycle, dintx=8'hA5; doutrx=8'hA5; back in IDLE after donetx.
// - Round-robin: all four valid, data 8'h10,8'h21,8'h32,8'h43 -> grants 0,1,2,3 in order; a re-asserted req0 is served only after 3.
// - ptr fairness: ptr=2 with valid=4'b0011 -> grant 0 first, then 1.
// - Timeout: donetx held 0 -> timeout_err pulse exactly 1248 cycles after entering WAIT_DONE; next grant accepted; ptr advanced.
// - Simultaneous: donetx at the cycle counter=1247 -> no timeout_err, normal return to IDLE.
// - Reset mid-frame: rst in WAIT_DONE -> next cycle IDLE with all outputs at reset values; ptr=0, so req0 wins over req2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// One byte per grant: newd pulse, then hold off until donetx or a frame timeout.
module uart_tx_arbiter #(
    parameter int unsigned clk_freq    = 1000000,
    parameter int unsigned baud_rate   = 9600,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_MUL = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       newd,
    output logic [7:0]                 dintx,
    input  logic                       donetx,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned CLKS_PER_BIT = clk_freq / baud_rate;
    localparam int unsigned TIMEOUT      = TIMEOUT_MUL * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = $clog2(TIMEOUT) + 1;
    localparam int unsigned ID_W         = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ID_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [7:0]        dintx_n;
    logic [ID_W-1:0]   grant_n;
    logic              newd_n, busy_n, terr_n;

    logic [ID_W-1:0]   g;
    logic              g_any;
    logic [ID_W:0]     idx;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        g     = '0;
        g_any = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!g_any && req_valid[idx[ID_W-1:0]]) begin
                g_any = 1'b1;
                g     = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && g_any) begin
            req_ready[g] = 1'b1;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        dintx_n = dintx;
        grant_n = grant_id;
        newd_n  = 1'b0;
        terr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (g_any) begin
                    dintx_n = req_data[32'(g)*8 +: 8];
                    grant_n = g;
                    ptr_n   = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
                    newd_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                cnt_n   = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done arriving on the timeout cycle takes precedence
                if (donetx) begin
                    state_n = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            dintx       <= 8'h00;
            grant_id    <= '0;
            newd        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            dintx       <= dintx_n;
            grant_id    <= grant_n;
            newd        <= newd_n;
            busy        <= busy_n;
            timeout_err <= terr_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with default parameters
// (CLKS_PER_BIT=104, TIMEOUT=1248); donetx is driven by the bench.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        newd;
    logic [7:0]  dintx;
    logic        donetx;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .clk_freq    (1000000),
        .baud_rate   (9600),
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_MUL (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .newd        (newd),
        .dintx       (dintx),
        .donetx      (donetx),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] d);
        req_data[8*i +: 8] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_newd"},  32'(newd), 32'h0);
        check({tag, "_dintx"}, 32'(dintx), 32'h0);
        check({tag, "_grant"}, 32'(grant_id), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_terr"},  32'(timeout_err), 32'h0);
    endtask

    // Expect requester exp_g to be accepted now, then complete its frame with donetx
    task automatic serve(input int exp_g, input logic [7:0] exp_d, input int wait_cycles);
        logic [3:0] rdy;
        #1;
        check("ready_onehot", 32'(req_ready), 32'(1) << exp_g);
        rdy = req_ready;
        tick;
        req_valid = req_valid & ~rdy;
        check("start_newd",  32'(newd), 32'h1);
        check("start_dintx", 32'(dintx), 32'(exp_d));
        check("start_grant", 32'(grant_id), 32'(exp_g));
        check("start_busy",  32'(busy), 32'h1);
        check("start_ready", 32'(req_ready), 32'h0);
        tick;
        check("wait_newd", 32'(newd), 32'h0);
        repeat (wait_cycles) tick;
        donetx = 1'b1;
        tick;
        donetx = 1'b0;
        check("done_busy",  32'(busy), 32'h0);
        check("done_terr",  32'(timeout_err), 32'h0);
        check("done_dintx", 32'(dintx), 32'(exp_d));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        donetx    = 1'b0;
        repeat (3) tick;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick;
        check_reset_outputs("idle");

        // Round-robin over four requesters; req0 re-asserts after its grant
        req_data  = 32'h43322110;
        req_valid = 4'b1111;
        serve(0, 8'h10, 5);
        req_valid[0] = 1'b1;
        set_byte(0, 8'h55);
        serve(1, 8'h21, 2);
        serve(2, 8'h32, 0);
        serve(3, 8'h43, 7);
        serve(0, 8'h55, 3);

        // Single requester; ptr=1 so search wraps back to 0
        set_byte(0, 8'hA5);
        req_valid = 4'b0001;
        serve(0, 8'hA5, 4);
        tick;
        check("idle_hold_dintx", 32'(dintx), 32'hA5);
        check("idle_hold_grant", 32'(grant_id), 32'h0);

        // Move ptr to 2, then 0 and 1 both valid: 0 wins, then 1
        set_byte(1, 8'h5A);
        req_valid = 4'b0010;
        serve(1, 8'h5A, 1);
        set_byte(0, 8'h01);
        set_byte(1, 8'h02);
        req_valid = 4'b0011;
        serve(0, 8'h01, 2);
        serve(1, 8'h02, 2);

        // Timeout on req2 (ptr=2 -> grant 2, ptr -> 3)
        set_byte(2, 8'hD2);
        req_valid = 4'b0100;
        #1;
        check("to_ready", 32'(req_ready), 32'h4);
        tick;
        req_valid = 4'b0000;
        check("to_newd", 32'(newd), 32'h1);
        tick;
        repeat (1247) tick;
        check("to_pre_terr", 32'(timeout_err), 32'h0);
        check("to_pre_busy", 32'(busy), 32'h1);
        tick;
        check("to_terr", 32'(timeout_err), 32'h1);
        check("to_busy", 32'(busy), 32'h0);

        // Accept in the timeout cycle; ptr advanced so 3 beats 2
        set_byte(3, 8'hC3);
        req_valid = 4'b1100;
        #1;
        check("post_to_ready", 32'(req_ready), 32'h8);
        tick;
        req_valid = 4'b0100;
        check("post_to_terr",  32'(timeout_err), 32'h0);
        check("post_to_newd",  32'(newd), 32'h1);
        check("post_to_grant", 32'(grant_id), 32'h3);
        check("post_to_dintx", 32'(dintx), 32'hC3);

        // donetx in START is ignored; then done coincides with the timeout cycle
        donetx = 1'b1;
        tick;
        donetx = 1'b0;
        check("start_done_busy", 32'(busy), 32'h1);
        repeat (1247) tick;
        check("sim_pre_busy", 32'(busy), 32'h1);
        donetx = 1'b1;
        tick;
        donetx = 1'b0;
        check("sim_terr", 32'(timeout_err), 32'h0);
        check("sim_busy", 32'(busy), 32'h0);
        #1;
        check("sim_ready", 32'(req_ready), 32'h4);

        // Pending req2 served next (ptr=0 -> search 0,1,2)
        serve(2, 8'hD2, 1);
        check("late_terr", 32'(timeout_err), 32'h0);

        // Reset mid-frame: grant req1 (ptr -> 2), reset in WAIT_DONE
        set_byte(1, 8'h66);
        req_valid = 4'b0010;
        #1;
        check("rmf_ready", 32'(req_ready), 32'h2);
        tick;
        req_valid = 4'b0000;
        tick;
        tick;
        check("rmf_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_reset_outputs("rmf");
        set_byte(0, 8'h11);
        set_byte(2, 8'h99);
        req_valid = 4'b0101;
        serve(0, 8'h11, 2);
        serve(2, 8'h99, 2);

        // donetx while idle has no effect
        donetx = 1'b1;
        tick;
        donetx = 1'b0;
        check("idle_done_busy", 32'(busy), 32'h0);
        check("idle_done_newd", 32'(newd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
